// File: rtl/tawa_uart_pkg.sv
// tawa_uart_pkg: shared types and constants for the encoder-link UART receiver.
// Optional feature macro used by the receiver: TAWA_UART_RX_MAJORITY_EN.
package tawa_uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per bit for a given system clock and baud rate.
  function automatic int calc_bps(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // 2-of-3 majority used by the optional glitch-rejecting bit decision.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam int   CLK_FREQ_DFLT = 50_000_000;
  localparam int   BAUD_DFLT     = 2_500_000;
  localparam int   BPS_CNT_DFLT  = calc_bps(CLK_FREQ_DFLT, BAUD_DFLT);
  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   DATA_BITS     = 8;
  localparam int   FLAG_HOLD     = BPS_CNT_DFLT;

endpackage

// File: rtl/tawa_uart_rx_sampler.sv
// tawa_uart_rx_sampler: 2-flop synchroniser, falling-edge detect and bit decision.
// With TAWA_UART_RX_MAJORITY_EN defined the bit value is a 2-of-3 vote around the
// sample point and is presented one cycle after it; otherwise a single sample.
module tawa_uart_rx_sampler
  import tawa_uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  input  logic i_samp_pt,
  output logic o_rx_s,
  output logic o_fall,
  output logic o_bit_val,
  output logic o_bit_vld
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Bring the asynchronous line into the clock domain and keep its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
      r_prev  <= IDLE_LEVEL;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rx_s = r_sync2;
  assign o_fall = (~r_sync2) & r_prev;

`ifdef TAWA_UART_RX_MAJORITY_EN
  logic [1:0] r_hist;
  logic       r_samp_d;

  // Keep the two previous synchronised samples and delay the sample strobe by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist   <= {2{IDLE_LEVEL}};
      r_samp_d <= 1'b0;
    end else begin
      r_hist   <= {r_hist[0], r_sync2};
      r_samp_d <= i_samp_pt;
    end
  end

  // r_hist[1] = sample point - 1, r_hist[0] = sample point, r_sync2 = sample point + 1.
  assign o_bit_val = maj3(r_hist[1], r_hist[0], r_sync2);
  assign o_bit_vld = r_samp_d;
`else
  assign o_bit_val = r_sync2;
  assign o_bit_vld = i_samp_pt;
`endif

endmodule

// File: rtl/tawa_uart_rx.sv
// tawa_uart_rx: 8N1 LSB-first receiver for the encoder link. Good bytes appear on
// data_in with flag_recv held for one bit period; bad stop bits pulse frame_err.
// Optional feature macro: TAWA_UART_RX_MAJORITY_EN (2-of-3 vote, decisions +1 cycle).
module tawa_uart_rx
  import tawa_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 2_500_000,
  parameter int BPS_CNT  = calc_bps(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_in,
  output logic       flag_recv,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int             CW       = $clog2(BPS_CNT);
  localparam int             FW       = $clog2(BPS_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0]  SAMP_PT  = CW'(BPS_CNT / 2 - 1);
  localparam logic [FW-1:0]  HOLD_CYC = FW'(BPS_CNT);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic [FW-1:0] r_flag_cnt;
  logic          r_flag;
  logic          r_err;
  logic          r_busy;

  logic w_rx_s;
  logic w_fall;
  logic w_bit_val;
  logic w_bit_vld;
  logic w_samp_pt;
  logic w_shift;
  logic w_idx_clr;
  logic w_load;
  logic w_err;

  // The timer only runs inside a frame, so the strobe never fires while idle.
  assign w_samp_pt = (r_state != IDLE) && (r_cnt == SAMP_PT);

  tawa_uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx      (rx),
    .i_samp_pt (w_samp_pt),
    .o_rx_s    (w_rx_s),
    .o_fall    (w_fall),
    .o_bit_val (w_bit_val),
    .o_bit_vld (w_bit_vld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; every decision waits for a qualified bit.
  always_comb begin
    w_next    = r_state;
    w_shift   = 1'b0;
    w_idx_clr = 1'b0;
    w_load    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: begin
        // A fall already implies the line is low; the level check keeps intent explicit.
        if (w_fall && (w_rx_s != IDLE_LEVEL)) begin
          w_next = START;
        end else begin
          w_next = IDLE;
        end
      end
      START: begin
        if (w_bit_vld) begin
          if (w_bit_val == IDLE_LEVEL) begin
            w_next = IDLE;
          end else begin
            w_next    = DATA;
            w_idx_clr = 1'b1;
          end
        end else begin
          w_next = START;
        end
      end
      DATA: begin
        if (w_bit_vld) begin
          w_shift = 1'b1;
          if (r_bit_idx == IDX_LAST) begin
            w_next = STOP;
          end else begin
            w_next = DATA;
          end
        end else begin
          w_next = DATA;
        end
      end
      STOP: begin
        if (w_bit_vld) begin
          w_next = IDLE;
          if (w_bit_val) begin
            w_load = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_next = STOP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Bit timer: held at zero while idle (this is the clear on the falling edge), wraps per bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == IDLE) || (r_cnt == CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shift register and bit index; LSB arrives first so bits enter at the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_idx <= 3'd0;
      r_sh      <= 8'h00;
    end else begin
      if (w_idx_clr) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_bit_idx <= r_bit_idx;
      end
      if (w_shift) begin
        r_sh <= {w_bit_val, r_sh[7:1]};
      end else begin
        r_sh <= r_sh;
      end
    end
  end

  // Output byte updates only on a good stop bit; framing errors leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= 8'h00;
    end else if (w_load) begin
      r_data <= r_sh;
    end else begin
      r_data <= r_data;
    end
  end

  // Received-flag hold counter; a new good byte reloads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag_cnt <= '0;
      r_flag     <= 1'b0;
    end else if (w_load) begin
      r_flag_cnt <= HOLD_CYC;
      r_flag     <= 1'b1;
    end else if (r_flag_cnt != '0) begin
      r_flag_cnt <= r_flag_cnt - FW'(1);
      r_flag     <= (r_flag_cnt != FW'(1));
    end else begin
      r_flag_cnt <= '0;
      r_flag     <= 1'b0;
    end
  end

  // Registered framing-error pulse and busy indication (busy mirrors state != IDLE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_err  <= w_err;
      r_busy <= (w_next != IDLE);
    end
  end

  assign data_in   = r_data;
  assign flag_recv = r_flag;
  assign frame_err = r_err;
  assign rx_busy   = r_busy;

endmodule

// File: tb/tb_tawa_uart_rx.sv
// tb_tawa_uart_rx: directed and randomized frames against a frame-level reference model.
module tb_tawa_uart_rx;

  localparam int BPS = 20;
  localparam int H   = BPS / 2;
`ifdef TAWA_UART_RX_MAJORITY_EN
  localparam int DLY = 1;
  localparam bit MAJ = 1'b1;
`else
  localparam int DLY = 0;
  localparam bit MAJ = 1'b0;
`endif
  // First low pin cycle -> output change: 2 sync + H + 9 bits + 1 register + vote delay.
  localparam int OUT_LAT = 2 + H + 9 * BPS + 1 + DLY;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_in;
  logic       flag_recv;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] got_bytes[$];
  int         rise_cyc[$];
  int         got_len[$];
  int         err_cyc[$];
  logic [7:0] exp_bytes[$];
  logic       mon_prev_flag = 1'b0;
  int         mon_len = 0;

  tawa_uart_rx #(.CLK_FREQ(50_000_000), .BAUD(2_500_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_in   (data_in),
    .flag_recv (flag_recv),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output events away from the active edge.
  always @(negedge clk) begin
    if (flag_recv && !mon_prev_flag) begin
      got_bytes.push_back(data_in);
      rise_cyc.push_back(cyc);
      mon_len = 0;
    end
    if (flag_recv) mon_len++;
    if (!flag_recv && mon_prev_flag) got_len.push_back(mon_len);
    if (frame_err) err_cyc.push_back(cyc);
    mon_prev_flag = flag_recv;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] get_byte(input int i);
    if (i < got_bytes.size()) return got_bytes[i];
    return 8'hxx;
  endfunction

  function automatic int get_rise(input int i);
    if (i < rise_cyc.size()) return rise_cyc[i];
    return -1;
  endfunction

  function automatic int get_len(input int i);
    if (i < got_len.size()) return got_len[i];
    return -1;
  endfunction

  function automatic int get_err(input int i);
    if (i < err_cyc.size()) return err_cyc[i];
    return -1;
  endfunction

  // Reference: a byte is the pin value at the middle of each data bit; a one-cycle
  // glitch there corrupts it unless the majority vote is built in.
  function automatic logic [7:0] model_byte(input logic [7:0] b, input int glitch_bit);
    logic [7:0] r;
    r = b;
    if (glitch_bit >= 0 && !MAJ) r[glitch_bit] = ~r[glitch_bit];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 10-bit frame; c0 is the cycle in which the start bit first appears.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int glitch_bit,
                            output int c0);
    logic lvl;
    for (int j = 0; j < 10; j++) begin
      for (int n = 0; n < BPS; n++) begin
        @(posedge clk);
        #1;
        if (j == 0 && n == 0) c0 = cyc;
        if (j == 0) lvl = 1'b0;
        else if (j == 9) lvl = stop_b;
        else lvl = b[j-1];
        if (glitch_bit >= 0 && j == glitch_bit + 1 && n == H) lvl = ~lvl;
        rx = lvl;
      end
    end
  endtask

  initial begin
    int c0;
    int c_first;
    int nb;
    int ne;
    int gap;
    int nexp_err;
    bit bad;
    logic [7:0] rb;
    logic [7:0] last_good;
    logic [7:0] b2b[11];

    // Reset state
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    chk("rst_data", data_in, 8'h00);
    chk("rst_flag", flag_recv, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // Good byte with exact timing
    nb = got_bytes.size();
    ne = err_cyc.size();
    send_frame(8'h1A, 1'b1, -1, c0);
    tick(30);
    chk("good_count", got_bytes.size(), nb + 1);
    chk("good_byte", get_byte(nb), 8'h1A);
    chk("good_time", get_rise(nb), c0 + OUT_LAT);
    chk("good_len", get_len(nb), BPS);
    chk("good_noerr", err_cyc.size(), ne);
    chk("good_data", data_in, 8'h1A);
    last_good = 8'h1A;

    // False start: 5 low cycles
    nb = got_bytes.size();
    @(posedge clk);
    #1;
    c0 = cyc;
    rx = 1'b0;
    tick(3);
    chk("fs_busy_hi", rx_busy, 1'b1);
    tick(2);
    rx = 1'b1;
    tick(8 + DLY);  // cycle E+11(+DLY): decision taken at E+10, state register updated
    chk("fs_busy_lo", rx_busy, 1'b0);
    tick(30);
    chk("fs_nobyte", got_bytes.size(), nb);
    chk("fs_data", data_in, last_good);
    chk("fs_noerr", err_cyc.size(), ne);

    // Framing error after 0x55, line held low afterwards
    send_frame(8'h55, 1'b1, -1, c0);
    tick(30);
    chk("fe_pre_byte", data_in, 8'h55);
    last_good = 8'h55;
    nb = got_bytes.size();
    ne = err_cyc.size();
    send_frame(8'hA3, 1'b0, -1, c0);
    tick(40);
    chk("fe_count", err_cyc.size(), ne + 1);
    chk("fe_time", get_err(ne), c0 + OUT_LAT);
    chk("fe_data", data_in, 8'h55);
    chk("fe_nobyte", got_bytes.size(), nb);
    chk("fe_stuck_idle", rx_busy, 1'b0);
    rx = 1'b1;
    tick(20);
    send_frame(8'h02, 1'b1, -1, c0);
    tick(30);
    chk("fe_next_count", got_bytes.size(), nb + 1);
    chk("fe_next_byte", get_byte(nb), 8'h02);
    last_good = 8'h02;

    // Back-to-back frames, no idle gap
    b2b[0] = 8'h1A;
    for (int i = 1; i < 11; i++) b2b[i] = 8'(i - 1);
    nb = got_bytes.size();
    c_first = 0;
    for (int i = 0; i < 11; i++) begin
      send_frame(b2b[i], 1'b1, -1, c0);
      if (i == 0) c_first = c0;
    end
    tick(30);
    chk("b2b_count", got_bytes.size(), nb + 11);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("b2b_byte%0d", i), get_byte(nb + i), b2b[i]);
      chk($sformatf("b2b_time%0d", i), get_rise(nb + i), c_first + i * 10 * BPS + OUT_LAT);
      chk($sformatf("b2b_len%0d", i), get_len(nb + i), BPS);
    end
    last_good = 8'h09;

    // Reset during data bit 4 of 0xFF
    nb = got_bytes.size();
    ne = err_cyc.size();
    fork
      send_frame(8'hFF, 1'b1, -1, c0);
      begin
        tick(105);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mr_data", data_in, 8'h00);
        chk("mr_flag", flag_recv, 1'b0);
        chk("mr_err", frame_err, 1'b0);
        chk("mr_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
      end
    join
    tick(30);
    chk("mr_nobyte", got_bytes.size(), nb);
    chk("mr_noerr", err_cyc.size(), ne);
    chk("mr_data_after", data_in, 8'h00);
    send_frame(8'h3C, 1'b1, -1, c0);
    tick(30);
    chk("mr_next_byte", get_byte(nb), 8'h3C);
    chk("mr_next_data", data_in, 8'h3C);

    // Glitch exactly at the bit-3 sample point
    nb = got_bytes.size();
    send_frame(8'h1A, 1'b1, 3, c0);
    tick(30);
    chk("glitch_byte", get_byte(nb), model_byte(8'h1A, 3));
    chk("glitch_data", data_in, model_byte(8'h1A, 3));
    last_good = model_byte(8'h1A, 3);

    // Randomized frames with random gaps and occasional bad stop bits
    nb = got_bytes.size();
    ne = err_cyc.size();
    nexp_err = 0;
    exp_bytes.delete();
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(rb, !bad, -1, c0);
      if (bad) begin
        nexp_err++;
      end else begin
        exp_bytes.push_back(rb);
        last_good = rb;
      end
      rx = 1'b1;
      gap = $urandom_range(0, 25);
      tick(gap);
    end
    tick(30);
    chk("rnd_count", got_bytes.size(), nb + exp_bytes.size());
    chk("rnd_errs", err_cyc.size(), ne + nexp_err);
    for (int i = 0; i < exp_bytes.size(); i++) begin
      chk($sformatf("rnd_byte%0d", i), get_byte(nb + i), exp_bytes[i]);
    end
    chk("rnd_data", data_in, last_good);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
